// File: rtl/key_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_pkg
// Purpose  : FSM encoding and elaboration helpers shared by key_debounce_array.
// Revision : 1.0
// ============================================================================
package key_debounce_pkg;

    typedef enum logic [1:0] {
        UP      = 2'd0,
        WAIT_DN = 2'd1,
        DOWN    = 2'd2,
        WAIT_UP = 2'd3
    } key_fsm_e;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int prescaler_tc(input int clk_hz);
        return (clk_hz / 1000) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_channel
// Purpose  : One key: 2-FF synchroniser, debounce FSM, ms counter, pulses.
//            Long-press detection present only with KEY_LONGPRESS_EN.
// Revision : 1.0
// ============================================================================
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic tick,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

`ifdef KEY_LONGPRESS_EN
    localparam int CNT_W = clog2(LONG_MS + 1);
`else
    localparam int CNT_W = clog2(DEBOUNCE_MS + 1);
`endif
    localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DEBOUNCE_MS);

    if (LONG_MS <= DEBOUNCE_MS) begin : g_cfg_check
        $error("key_debounce_channel: LONG_MS must exceed DEBOUNCE_MS");
    end

    logic [1:0]       sync_q, sync_d;
    logic             pressed;
    key_fsm_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             key_state_q, key_state_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
`ifdef KEY_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_MS - DEBOUNCE_MS);
    logic             long_q, long_d;
    logic             long_done_q, long_done_d;
`endif

    always_comb begin
        sync_d      = {sync_q[0], key_in};
        pressed     = sync_q[1] ^ ACTIVE_LOW;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_state_d = key_state_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
`ifdef KEY_LONGPRESS_EN
        long_d      = 1'b0;
        long_done_d = long_done_q;
`endif
        // A level change always takes priority over a coincident tick.
        case (state_q)
            UP: begin
                if (pressed) begin
                    state_d = WAIT_DN;
                    cnt_d   = '0;
                end
            end
            WAIT_DN: begin
                if (!pressed) begin
                    state_d = UP;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_CNT) begin
                        state_d     = DOWN;
                        key_state_d = 1'b1;
                        press_d     = 1'b1;
                        cnt_d       = '0;
`ifdef KEY_LONGPRESS_EN
                        long_done_d = 1'b0;
`endif
                    end
                end
            end
            DOWN: begin
                if (!pressed) begin
                    state_d = WAIT_UP;
                    cnt_d   = '0;
                end
`ifdef KEY_LONGPRESS_EN
                else if (tick) begin
                    cnt_d = cnt_inc;
                    // Done flag keeps a bounce-restarted hold from firing twice.
                    if (cnt_inc == LONG_CNT && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
`endif
            end
            WAIT_UP: begin
                if (pressed) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DB_CNT) begin
                        state_d     = UP;
                        key_state_d = 1'b0;
                        release_d   = 1'b1;
                        cnt_d       = '0;
                    end
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q      <= {ACTIVE_LOW, ACTIVE_LOW};
            state_q     <= UP;
            cnt_q       <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
`ifdef KEY_LONGPRESS_EN
            long_q      <= 1'b0;
            long_done_q <= 1'b0;
`endif
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
`ifdef KEY_LONGPRESS_EN
            long_q      <= long_d;
            long_done_q <= long_done_d;
`endif
        end
    end

    assign key_state     = key_state_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`ifdef KEY_LONGPRESS_EN
    assign long_pulse    = long_q;
`else
    assign long_pulse    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/key_debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce_array
// Purpose  : N-key debouncer sharing one 1 ms prescaler; KEY_LONGPRESS_EN
//            enables per-key long-press pulses.
// Revision : 1.0
// ============================================================================
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [N_KEYS-1:0] Key_In,
    output logic [N_KEYS-1:0] Key_State,
    output logic [N_KEYS-1:0] Press_Pulse,
    output logic [N_KEYS-1:0] Release_Pulse,
    output logic [N_KEYS-1:0] Long_Pulse
);

    localparam int PRE_TC = prescaler_tc(CLK_HZ);
    localparam int PRE_W  = clog2(CLK_HZ / 1000);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick;

    always_comb begin
        tick      = (pre_cnt_q == PRE_W'(PRE_TC));
        pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_channel (
            .CLK           (CLK),
            .RST_n         (RST_n),
            .tick          (tick),
            .key_in        (Key_In[i]),
            .key_state     (Key_State[i]),
            .press_pulse   (Press_Pulse[i]),
            .release_pulse (Release_Pulse[i]),
            .long_pulse    (Long_Pulse[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce_array
// Purpose  : Directed bench with a per-cycle behavioural model of the debouncer.
// Revision : 1.0
// ============================================================================
module tb_key_debounce_array;

    localparam int P = 10;
    localparam int D = 4;
    localparam int L = 20;
`ifdef KEY_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic [3:0] Key_In = 4'hF;
    logic [3:0] Key_State, Press_Pulse, Release_Pulse, Long_Pulse;

    key_debounce_array #(
        .N_KEYS      (4),
        .CLK_HZ      (10_000),
        .DEBOUNCE_MS (D),
        .LONG_MS     (L),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .CLK           (CLK),
        .RST_n         (RST_n),
        .Key_In        (Key_In),
        .Key_State     (Key_State),
        .Press_Pulse   (Press_Pulse),
        .Release_Pulse (Release_Pulse),
        .Long_Pulse    (Long_Pulse)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit run_chk  = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Model: a key flips once its synchronised level has disagreed with the
    // debounced state through D ms ticks, not counting the first disagreeing
    // cycle; long press = L-D ticks of undisturbed hold after confirmation.
    int         m_pc;
    logic [3:0] m_h1, m_h2;
    bit         m_ks [4];
    int         m_dis [4];
    int         m_dt [4];
    int         m_ht [4];
    bit         m_ld [4];
    bit         m_tick, m_lev;
    logic [3:0] e_state = '0, e_press = '0, e_rel = '0, e_long = '0;

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_pc = 0; m_h1 = 4'hF; m_h2 = 4'hF;
            e_state = '0; e_press = '0; e_rel = '0; e_long = '0;
            for (int k = 0; k < 4; k++) begin
                m_ks[k] = 0; m_dis[k] = 0; m_dt[k] = 0; m_ht[k] = 0; m_ld[k] = 0;
            end
        end else begin
            m_tick = (m_pc == P - 1);
            m_pc   = (m_pc + 1) % P;
            e_press = '0; e_rel = '0; e_long = '0;
            for (int k = 0; k < 4; k++) begin
                m_lev = ~m_h2[k];
                if (m_lev != m_ks[k]) begin
                    if (m_dis[k] > 0 && m_tick) m_dt[k]++;
                    m_dis[k]++;
                    if (m_dt[k] == D) begin
                        m_ks[k] = m_lev;
                        if (m_lev) begin
                            e_press[k] = 1'b1; m_ht[k] = 0; m_ld[k] = 0;
                        end else begin
                            e_rel[k] = 1'b1;
                        end
                        m_dis[k] = 0; m_dt[k] = 0;
                    end
                end else begin
                    if (m_ks[k] && m_dis[k] > 0) begin
                        m_ht[k] = 0;
                    end else if (m_ks[k] && m_tick) begin
                        m_ht[k]++;
                        if (m_ht[k] == L - D && !m_ld[k]) begin
                            e_long[k] = LONG_EN; m_ld[k] = 1;
                        end
                    end
                    m_dis[k] = 0; m_dt[k] = 0;
                end
                e_state[k] = m_ks[k];
            end
            m_h2 = m_h1;
            m_h1 = Key_In;
        end
    end

    int press_cnt [4] = '{0, 0, 0, 0};
    int long_cnt  [4] = '{0, 0, 0, 0};
    int long_at   [4] = '{-1, -1, -1, -1};

    always @(negedge CLK) begin
        if (run_chk) begin
            check("cmp Key_State", int'(Key_State), int'(e_state));
            check("cmp Press_Pulse", int'(Press_Pulse), int'(e_press));
            check("cmp Release_Pulse", int'(Release_Pulse), int'(e_rel));
            check("cmp Long_Pulse", int'(Long_Pulse), int'(e_long));
            for (int k = 0; k < 4; k++) begin
                if (Press_Pulse[k]) press_cnt[k]++;
                if (Long_Pulse[k]) begin
                    long_cnt[k]++;
                    long_at[k] = cyc;
                end
            end
        end
    end

    // kind: 0 press, 1 release, 2 long. Returns -1 if the budget expires.
    task automatic wait_pulse(input int kind, input int k, input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc && at < 0; i++) begin
            @(negedge CLK);
            case (kind)
                0:       if (Press_Pulse[k])   at = cyc;
                1:       if (Release_Pulse[k]) at = cyc;
                default: if (Long_Pulse[k])    at = cyc;
            endcase
        end
    endtask

    initial begin
        int t0, at, p;
        repeat (3) @(posedge CLK);
        run_chk = 1'b1;
        @(posedge CLK); #1 RST_n = 1'b1;
        @(negedge CLK);
        check("reset_outputs", int'({Key_State, Press_Pulse, Release_Pulse, Long_Pulse}), 0);

        // Single steady press on key 0.
        Key_In[0] = 1'b0; t0 = cyc + 1;
        wait_pulse(0, 0, 60, at);
        check_range("press0_latency", at - t0, 33, 42);
        @(negedge CLK);
        check("press0_width", int'(Press_Pulse[0]), 0);
        check("press0_state", int'(Key_State), 4'b0001);
        check("press_others", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // Key 1 bouncing every 15 cycles, then steady.
        for (int i = 0; i < 100; i++) begin
            Key_In[1] = (i % 15 == 14) ? 1'b1 : 1'b0;
            if (i == 90) t0 = cyc + 1;
            @(negedge CLK);
        end
        check("bounce1_no_press", press_cnt[1], 0);
        wait_pulse(0, 1, 60, at);
        check_range("bounce1_latency", at - t0, 33, 42);

        // Release key 0, then key 1.
        @(negedge CLK);
        Key_In[0] = 1'b1; t0 = cyc + 1;
        wait_pulse(1, 0, 60, at);
        check_range("release0_latency", at - t0, 33, 42);
        @(negedge CLK);
        check("release0_state", int'(Key_State[0]), 0);
        Key_In[1] = 1'b1;
        wait_pulse(1, 1, 60, at);
        check("release1_seen", int'(at > 0), 1);

        // Long hold on key 2.
        @(negedge CLK);
        Key_In[2] = 1'b0; t0 = cyc + 1;
        wait_pulse(0, 2, 60, p);
        check_range("press2_latency", p - t0, 33, 42);
        while (cyc < t0 + 300) @(negedge CLK);
        check("long2_count", long_cnt[2], int'(LONG_EN));
        if (long_cnt[2] != 0) check_range("long2_delay", long_at[2] - p, 160, 170);
        Key_In[2] = 1'b1;
        wait_pulse(1, 2, 60, at);

        // Keys 0 and 3 pressed together.
        @(negedge CLK);
        Key_In[0] = 1'b0; Key_In[3] = 1'b0;
        wait_pulse(0, 0, 60, at);
        check("simul_press3", int'(Press_Pulse[3]), 1);
        check("simul_state", int'(Key_State), 4'b1001);
        @(negedge CLK);
        Key_In[0] = 1'b1; Key_In[3] = 1'b1;
        wait_pulse(1, 0, 60, at);
        check("simul_release3", int'(Release_Pulse[3]), 1);

        // Reset with key 1 mid-debounce and key 2 held.
        @(negedge CLK);
        Key_In[2] = 1'b0;
        wait_pulse(0, 2, 60, at);
        Key_In[1] = 1'b0;
        repeat (10) @(negedge CLK);
        @(posedge CLK); #1 RST_n = 1'b0;
        #1 check("reset_async_outputs",
                 int'({Key_State, Press_Pulse, Release_Pulse, Long_Pulse}), 0);
        Key_In[1] = 1'b1;
        repeat (3) @(negedge CLK);
        @(posedge CLK); #1 RST_n = 1'b1; t0 = cyc + 1;
        wait_pulse(0, 2, 60, at);
        check_range("repress2_latency", at - t0, 33, 42);
        @(negedge CLK);
        Key_In[2] = 1'b1;
        wait_pulse(1, 2, 60, at);
        @(negedge CLK);
        check("final_state", int'(Key_State), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
